tdc_multi_uart: RTL and testbench



---
 rtl/tdc_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 50 +++++
 rtl/tdc_multi_uart.sv | 166 ++++++++++++++++
 tb/tb_tdc_multi_uart.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the multi-channel TDC with UART reporter.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Header byte layout: {valid, 4'b0000, channel[2:0]}
  localparam int unsigned VALID_BIT = 7;
  localparam int unsigned CH_LSB    = 0;
  localparam int unsigned CH_W      = 3;

  function automatic int unsigned bytes_per_ch(input int unsigned cnt_w);
    return 1 + cnt_w / 8;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first. ready is raised during the final stop-bit
// cycle so that a byte loaded then follows with no idle gap.
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);
  localparam int unsigned   BW       = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] LAST     = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] STOP_END = BW'(BAUD_DIV - 2);

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;

  // bit_idx 0 = start bit, 1..8 = data, 9 = stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      ready    <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (ready) begin
      if (load) begin
        ready    <= 1'b0;
        tx       <= 1'b0;
        shreg    <= {1'b1, data};
        baud_cnt <= '0;
        bit_idx  <= '0;
      end
    end else if (bit_idx == 4'd9 && baud_cnt == STOP_END) begin
      ready    <= 1'b1;
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
      bit_idx  <= bit_idx + 4'd1;
      tx       <= shreg[0];
      shreg    <= {1'b0, shreg[8:1]};
    end else begin
      baud_cnt <= baud_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/tdc_multi_uart.sv
// Multi-channel coarse TDC: shared counter launched by start, first stop edge
// per channel captured, results reported over 8N1 UART followed by an eot pulse.
module tdc_multi_uart
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned BAUD_DIV = 87
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] stop,
  input  logic              mode_cont,
  output logic              tx,
  output logic              busy,
  output logic              eot
);
  localparam int unsigned NB   = CNT_W / 8;
  localparam int unsigned BPC  = bytes_per_ch(CNT_W);
  localparam int unsigned CI_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BI_W = $clog2(BPC);

  logic [2:0]        start_sy;
  logic [NUM_CH-1:0] stop_s1, stop_s2, stop_s3;
  logic [1:0]        mode_sy;
  logic              start_edge;
  logic [NUM_CH-1:0] stop_edge;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cap [NUM_CH];
  logic [NUM_CH-1:0] valid;
  logic [CI_W-1:0]   ch_idx;
  logic [BI_W-1:0]   byte_idx;
  logic              last_loaded;

  logic              tx_ready;
  logic              load_c;
  logic [7:0]        byte_c;
  logic              done_c;
  logic              all_valid_c;
  logic              timeout_c;

  // 2-FF synchronisers plus one extra stage for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sy <= '0;
      stop_s1  <= '0;
      stop_s2  <= '0;
      stop_s3  <= '0;
      mode_sy  <= '0;
    end else begin
      start_sy <= {start_sy[1:0], start};
      stop_s1  <= stop;
      stop_s2  <= stop_s1;
      stop_s3  <= stop_s2;
      mode_sy  <= {mode_sy[0], mode_cont};
    end
  end

  assign start_edge  = start_sy[1] & ~start_sy[2];
  assign stop_edge   = stop_s2 & ~stop_s3;
  assign all_valid_c = &(valid | stop_edge);
  assign timeout_c   = (cnt == '1);
  assign done_c      = (state == SEND) && tx_ready && last_loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = ARMED;
      ARMED:   if (all_valid_c || timeout_c) state_nxt = SEND;
      SEND:    if (done_c) state_nxt = mode_sy[1] ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte selection: header first, then capture MSB first
  always_comb begin
    load_c = 1'b0;
    byte_c = '0;
    if (state == SEND && tx_ready && !last_loaded) begin
      load_c = 1'b1;
      if (byte_idx == '0) begin
        byte_c[VALID_BIT]         = valid[ch_idx];
        byte_c[CH_LSB +: CH_W]    = CH_W'(ch_idx);
      end else begin
        byte_c = 8'(cap[ch_idx] >> (8 * (NB - 32'(byte_idx))));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      valid       <= '0;
      ch_idx      <= '0;
      byte_idx    <= '0;
      last_loaded <= 1'b0;
      busy        <= 1'b0;
      eot         <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cap[i] <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      eot  <= done_c;
      case (state)
        IDLE: begin
          if (start_edge) begin
            cnt   <= '0;
            valid <= '0;
          end
        end
        ARMED: begin
          ch_idx      <= '0;
          byte_idx    <= '0;
          last_loaded <= 1'b0;
          if (!timeout_c) cnt <= cnt + CNT_W'(1);
          // Channels still open at saturation report all-ones with valid=0
          for (int i = 0; i < NUM_CH; i++) begin
            if (!valid[i]) begin
              if (stop_edge[i]) begin
                cap[i]   <= cnt;
                valid[i] <= 1'b1;
              end else if (timeout_c) begin
                cap[i] <= '1;
              end
            end
          end
        end
        SEND: begin
          if (load_c) begin
            if (byte_idx == BI_W'(BPC - 1)) begin
              byte_idx <= '0;
              if (ch_idx == CI_W'(NUM_CH - 1)) last_loaded <= 1'b1;
              else                             ch_idx      <= ch_idx + CI_W'(1);
            end else begin
              byte_idx <= byte_idx + BI_W'(1);
            end
          end
          if (done_c && mode_sy[1]) begin
            cnt   <= '0;
            valid <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .data  (byte_c),
    .tx    (tx),
    .ready (tx_ready)
  );

endmodule

// File: tb/tb_tdc_multi_uart.sv
// Randomised and directed bench for tdc_multi_uart with a UART decoder and a
// reference model deriving each report from the first stop pulse per channel.
module tb_tdc_multi_uart;
  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BAUD_DIV = 8;
  localparam int unsigned NB       = CNT_W / 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              start     = 1'b0;
  logic [NUM_CH-1:0] stop      = '0;
  logic              mode_cont = 1'b0;
  logic              tx, busy, eot;

  int n_chk = 0, n_pass = 0, cyc = 0, rst_gen = 0;
  // Stop pulse offsets per channel, in counts after the measurement arms; -1 unused
  int pul [NUM_CH][3];
  logic [7:0] rx_q[$], exp_q[$];
  int rx_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_gen++;

  tdc_multi_uart #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_cont(mode_cont), .tx(tx), .busy(busy), .eot(eot)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // UART receiver sampling mid-bit; frames cut by a reset are discarded
  initial begin : uart_rx
    int g, t0;
    logic [7:0] b;
    logic sb;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        g  = rst_gen;
        t0 = cyc;
        repeat (BAUD_DIV / 2) @(negedge clk);
        sb = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (BAUD_DIV) @(negedge clk);
          b[k] = tx;
        end
        repeat (BAUD_DIV) @(negedge clk);
        if (g == rst_gen) begin
          check("rx_start_bit", sb, 0);
          check("rx_stop_bit", tx, 1);
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic clear_pul();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 3; k++) pul[c][k] = -1;
  endtask

  // Reference: earliest pulse wins; no pulse means timeout (invalid, all-ones)
  task automatic build_exp();
    int first;
    logic [CNT_W-1:0] v;
    logic [7:0] h;
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      first = -1;
      for (int k = 0; k < 3; k++)
        if (pul[c][k] >= 0 && (first < 0 || pul[c][k] < first)) first = pul[c][k];
      h = 8'(c);
      h[7] = (first >= 0);
      v = (first >= 0) ? CNT_W'(first) : '1;
      exp_q.push_back(h);
      for (int b = NB - 1; b >= 0; b--) exp_q.push_back(8'(v >> (8 * b)));
    end
  endtask

  // Pin offset for count d is lead+d negedges from now (1 after a start, -2 after eot)
  task automatic drive(input int lead, input bit do_start);
    int last;
    last = 0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 3; k++)
        if (pul[c][k] >= 0 && pul[c][k] + lead > last) last = pul[c][k] + lead;
    for (int j = 0; j <= last + 1; j++) begin
      start = (do_start && j == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        stop[c] = 1'b0;
        for (int k = 0; k < 3; k++)
          if (pul[c][k] >= 0 && pul[c][k] + lead == j) stop[c] = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    stop  = '0;
  endtask

  task automatic wait_eot(input int tmo);
    int t;
    t = 0;
    while (eot !== 1'b1 && t < tmo) begin
      @(negedge clk);
      t++;
    end
    check("eot_seen", eot, 1);
  endtask

  task automatic check_report(input bit cont);
    build_exp();
    check("rx_len", rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      check($sformatf("rx_byte%0d", k), rx_q[k], exp_q[k]);
      if (k > 0) check($sformatf("rx_gap%0d", k), rx_t[k] - rx_t[k-1], 10 * BAUD_DIV);
    end
    rx_q.delete();
    rx_t.delete();
    check("busy_at_eot", busy, cont);
    if (!cont) begin
      @(negedge clk);
      check("eot_width", eot, 0);
    end
  endtask

  task automatic single_round(input int tmo);
    drive(1, 1'b1);
    check("busy_armed", busy, 1);
    wait_eot(tmo);
    check_report(1'b0);
  endtask

  initial begin : main
    int t;
    clear_pul();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_eot", eot, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Staggered stops
    pul[0][0] = 10; pul[1][0] = 20; pul[2][0] = 30; pul[3][0] = 40;
    single_round(3000);

    // Only ch1 stops: counter saturates
    clear_pul();
    pul[1][0] = 5;
    single_round(70000);

    // Repeated pulses on ch2: first edge only
    clear_pul();
    pul[0][0] = 12; pul[1][0] = 60; pul[3][0] = 33;
    pul[2][0] = 7;  pul[2][1] = 9;  pul[2][2] = 50;
    single_round(3000);

    // ch0 and ch3 in the same cycle
    clear_pul();
    pul[0][0] = 25; pul[1][0] = 14; pul[2][0] = 40; pul[3][0] = 25;
    single_round(3000);

    // Continuous mode: second round re-arms without a start
    mode_cont = 1'b1;
    repeat (5) @(negedge clk);
    clear_pul();
    pul[0][0] = 6; pul[1][0] = 11; pul[2][0] = 17; pul[3][0] = 23;
    drive(1, 1'b1);
    wait_eot(3000);
    check_report(1'b1);
    clear_pul();
    pul[0][0] = 9; pul[1][0] = 4; pul[2][0] = 30; pul[3][0] = 2;
    drive(-2, 1'b0);
    mode_cont = 1'b0;
    wait_eot(3000);
    check_report(1'b0);

    // Reset in the middle of the second byte
    clear_pul();
    pul[0][0] = 3; pul[1][0] = 4; pul[2][0] = 5; pul[3][0] = 6;
    drive(1, 1'b1);
    t = 0;
    while (rx_q.size() == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rx_first_byte", rx_q.size() > 0, 1);
    repeat (30) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    rx_q.delete();
    rx_t.delete();

    // Random rounds, the first one straight after the reset
    for (int r = 0; r < 2; r++) begin
      clear_pul();
      for (int c = 0; c < NUM_CH; c++) begin
        pul[c][0] = int'($urandom_range(2, 120));
        if ($urandom_range(0, 1) == 1) pul[c][1] = int'($urandom_range(2, 160));
      end
      single_round(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
